// File: rtl/subexpr_pkg.sv
// Shared types for the subexpr_sched evaluator: FSM states, adder op select
// and the minimum input-to-output latency.
package subexpr_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        ADD1 = 4'd1,
        SUB  = 4'd2,
        MUL  = 4'd3,
        CD   = 4'd4,
        S4   = 4'd5,
        S6A  = 4'd6,
        S6B  = 4'd7,
        S6C  = 4'd8,
        S6D  = 4'd9,
        WMOD = 4'd10,
        OUT  = 4'd11
    } state_e;

    // Adder op labels are prefixed so they cannot collide with the SUB state.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } alu_op_e;

    localparam int LAT_MIN = 11;

endpackage

// File: rtl/subexpr_sched_seq_mod.sv
// Iterative restoring remainder: one quotient bit per clock, done pulses exactly
// BW cycles after start. A zero divisor yields the dividend as the remainder.
module seq_mod #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [BW-1:0] dividend,
    input  logic [BW-1:0] divisor,
    output logic          done,
    output logic [BW-1:0] rem
);

    localparam int CW = $clog2(BW + 1);

    logic [BW-1:0] rem_q;
    logic [BW-1:0] dvd_q;
    logic [BW-1:0] dsr_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          zero_q;
    logic          done_q;

    // NOTE: blocking assignments are correct here -- sh is a local temporary
    // inside a function, not a flop.
    function automatic logic [BW-1:0] rstep(input logic [BW-1:0] r,
                                            input logic          nb,
                                            input logic [BW-1:0] dv);
        logic [BW:0] sh;
        sh = {r, nb};
        if (sh >= {1'b0, dv}) sh = sh - {1'b0, dv};
        return sh[BW-1:0];
    endfunction

    // The first iteration runs on the start edge so the last lands BW-1 edges later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            zero_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                dsr_q  <= divisor;
                zero_q <= (divisor == '0);
                rem_q  <= (divisor == '0) ? dividend : rstep('0, dividend[BW-1], divisor);
                dvd_q  <= dividend << 1;
                cnt_q  <= CW'(BW - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (!zero_q) rem_q <= rstep(rem_q, dvd_q[BW-1], dsr_q);
                dvd_q <= dvd_q << 1;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign rem  = rem_q;

endmodule

// File: rtl/subexpr_sched.sv
// Time-multiplexed evaluator for s1..s6 over one shared adder, one multiplier
// and the iterative remainder unit; valid/ready on both sides.
module subexpr_sched
    import subexpr_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic [BW-1:0] c,
    input  logic [BW-1:0] d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] s1,
    output logic [BW-1:0] s2,
    output logic [BW-1:0] s3,
    output logic [BW-1:0] s4,
    output logic [BW-1:0] s5,
    output logic [BW-1:0] s6,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [BW-1:0] a_q, b_q, c_q, d_q;
    logic [BW-1:0] s1_q, s2_q, s3_q, s4_q, s5_q, s6_q;
    logic [BW-1:0] p_q, t_q, u_q, r_q;
    logic          sticky_q;

    logic          rem_start;
    logic          rem_done;
    logic [BW-1:0] rem_val;
    alu_op_e       alu_op;
    logic [BW-1:0] alu_x, alu_y, alu_res, mul_lo;

    seq_mod #(.BW(BW)) u_mod (
        .clk      (clk),
        .rst      (rst),
        .start    (rem_start),
        .dividend (a_q),
        .divisor  (b_q),
        .done     (rem_done),
        .rem      (rem_val)
    );

    assign alu_res = (alu_op == OP_SUB) ? alu_x - alu_y : alu_x + alu_y;
    assign mul_lo  = a_q * b_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ADD1;
            ADD1:    state_d = SUB;
            SUB:     state_d = MUL;
            MUL:     state_d = CD;
            CD:      state_d = S4;
            S4:      state_d = S6A;
            S6A:     state_d = S6B;
            S6B:     state_d = S6C;
            S6C:     state_d = S6D;
            S6D:     state_d = WMOD;
            WMOD:    if (sticky_q) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rem_start = 1'b0;
        alu_op    = OP_ADD;
        alu_x     = a_q;
        alu_y     = b_q;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ADD1: rem_start = 1'b1;
            SUB:  alu_op = OP_SUB;
            CD:   begin alu_x = c_q; alu_y = d_q; end
            S4:   begin alu_x = t_q; alu_y = p_q; end
            S6A:  begin alu_x = p_q; alu_y = a_q; end
            S6B:  begin alu_x = u_q; alu_y = d_q; end
            S6C:  begin alu_x = u_q; alu_y = c_q; end
            S6D:  begin alu_x = u_q; alu_y = b_q; alu_op = OP_SUB; end
            WMOD: begin alu_x = r_q; alu_y = d_q; end
            OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {a_q, b_q, c_q, d_q}                   <= '0;
            {s1_q, s2_q, s3_q, s4_q, s5_q, s6_q}   <= '0;
            {p_q, t_q, u_q, r_q}                   <= '0;
            sticky_q                               <= 1'b0;
        end else begin
            if (rem_done) begin
                r_q      <= rem_val;
                sticky_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q <= a;
                    b_q <= b;
                    c_q <= c;
                    d_q <= d;
                end
                ADD1: s1_q <= alu_res;
                SUB:  s5_q <= alu_res;
                MUL:  begin p_q <= mul_lo; s2_q <= mul_lo; end
                CD:   t_q  <= alu_res;
                S4:   s4_q <= alu_res;
                S6A, S6B, S6C: u_q <= alu_res;
                S6D:  s6_q <= alu_res;
                WMOD: if (sticky_q) s3_q <= alu_res;
                OUT:  if (out_ready) sticky_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign s1 = s1_q;
    assign s2 = s2_q;
    assign s3 = s3_q;
    assign s4 = s4_q;
    assign s5 = s5_q;
    assign s6 = s6_q;

endmodule

// File: tb/tb_subexpr_sched.sv
// Directed bench for subexpr_sched: an 8-bit instance for the main schedule,
// wrap, divide-by-zero, back-pressure and reset abort; a 16-bit instance for latency.
module tb_subexpr_sched;
    import subexpr_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic       in_ready, out_valid, busy;
    logic [7:0] a = '0, b = '0, c = '0, d = '0;
    logic [7:0] s1, s2, s3, s4, s5, s6;

    logic        w_in_valid = 1'b0, w_out_ready = 1'b1;
    logic        w_in_ready, w_out_valid, w_busy;
    logic [15:0] w_a = '0, w_b = '0, w_c = '0, w_d = '0;
    logic [15:0] w_s1, w_s2, w_s3, w_s4, w_s5, w_s6;

    always #5 clk = ~clk;

    subexpr_sched #(.BW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6), .busy(busy)
    );

    subexpr_sched #(.BW(16)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .c(w_c), .d(w_d), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .s1(w_s1), .s2(w_s2), .s3(w_s3), .s4(w_s4), .s5(w_s5), .s6(w_s6), .busy(w_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one operand set; returns in cycle 1 with junk on the operand inputs.
    task automatic send(input logic [7:0] va, vb, vc, vd);
        int k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) check("send_in_ready_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a = va; b = vb; c = vc; d = vd;
        tick();
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h00; c = 8'hFF; d = 8'h3C;
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic check_res(input string tag, input logic [7:0] e1, e2, e3, e4, e5, e6);
        check({tag, "_s1"}, 64'(s1), 64'(e1));
        check({tag, "_s2"}, 64'(s2), 64'(e2));
        check({tag, "_s3"}, 64'(s3), 64'(e3));
        check({tag, "_s4"}, 64'(s4), 64'(e4));
        check({tag, "_s5"}, 64'(s5), 64'(e5));
        check({tag, "_s6"}, 64'(s6), 64'(e6));
    endtask

    task automatic check_idle_after(input string tag);
        tick();
        check({tag, "_out_valid_drop"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_in_ready_back"},  {63'd0, in_ready},  64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat8;
        int n;
        lat8 = (8 + 3 > LAT_MIN) ? 8 + 3 : LAT_MIN;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_results",   {16'd0, s1, s2, s3, s4, s5, s6}, 64'd0);

        // Basic set: s6 = (b+1)*a + d + c - b, s3 = a mod b + d.
        send(8'd7, 8'd3, 8'd10, 8'd5);
        check("basic_busy",     {63'd0, busy},     64'd1);
        check("basic_in_ready", {63'd0, in_ready}, 64'd0);
        wait_out("basic", lat8);
        check_res("basic", 8'd10, 8'd21, 8'd6, 8'd36, 8'd4, 8'd40);
        check_idle_after("basic");

        send(8'd200, 8'd100, 8'd50, 8'd60);
        wait_out("wrap", lat8);
        check_res("wrap", 8'd44, 8'd32, 8'd60, 8'd142, 8'd100, 8'd242);
        check_idle_after("wrap");

        send(8'd9, 8'd0, 8'd1, 8'd2);
        wait_out("div0", lat8);
        check_res("div0", 8'd9, 8'd0, 8'd11, 8'd3, 8'd9, 8'd12);
        check_idle_after("div0");

        // Back-pressure: hold OUT for 20 cycles while a second set is offered.
        out_ready = 1'b0;
        send(8'd20, 8'd6, 8'd1, 8'd2);
        wait_out("bp", lat8);
        check_res("bp", 8'd26, 8'd120, 8'd4, 8'd123, 8'd14, 8'd137);
        in_valid = 1'b1;
        a = 8'd12; b = 8'd4; c = 8'd3; d = 8'd9;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_results", {16'd0, s1, s2, s3, s4, s5, s6},
                  {16'd0, 8'd26, 8'd120, 8'd4, 8'd123, 8'd14, 8'd137});
            check("bp_hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_in_ready",  {63'd0, in_ready},  64'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready",  {63'd0, in_ready},  64'd1);
        check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        send(8'd12, 8'd4, 8'd3, 8'd9);
        wait_out("bp2", lat8);
        check_res("bp2", 8'd16, 8'd48, 8'd9, 8'd60, 8'd8, 8'd68);
        check_idle_after("bp2");

        // Reset during cycle 5 of an operation aborts it completely.
        send(8'd50, 8'd6, 8'd7, 8'd8);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_results",   {16'd0, s1, s2, s3, s4, s5, s6}, 64'd0);
        check("abort_in_ready",  {63'd0, in_ready},  64'd1);
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_busy",      {63'd0, busy},      64'd0);
        send(8'd3, 8'd5, 8'd0, 8'd0);
        wait_out("post_abort", lat8);
        check_res("post_abort", 8'd8, 8'd15, 8'd3, 8'd15, 8'd254, 8'd13);
        check_idle_after("post_abort");

        // 16-bit instance: latency grows to BW+3.
        w_in_valid = 1'b1;
        w_a = 16'd1000; w_b = 16'd7; w_c = 16'd0; w_d = 16'd0;
        check("w_in_ready", {63'd0, w_in_ready}, 64'd1);
        tick();
        w_in_valid = 1'b0;
        w_a = 16'hBEEF; w_b = 16'h0; w_c = 16'h1234; w_d = 16'hFFFF;
        n = 1;
        while (!w_out_valid && n < 100) begin
            tick();
            n++;
        end
        check("w_latency", 64'(n), 64'd19);
        check("w_s1", 64'(w_s1), 64'd1007);
        check("w_s2", 64'(w_s2), 64'd7000);
        check("w_s3", 64'(w_s3), 64'd6);
        check("w_s4", 64'(w_s4), 64'd7000);
        check("w_s5", 64'(w_s5), 64'd993);
        check("w_s6", 64'(w_s6), 64'd7993);
        check("w_busy", {63'd0, w_busy}, 64'd1);
        tick();
        check("w_in_ready_back", {63'd0, w_in_ready}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
